imem_fetch_arbiter: RTL and testbench

- Sequences instruction fetch into the single-ported instruction memory and shares that port with the DMA engine.
- Drives PC update (pc_write/pc_next) to the prefetch buffer, qualifies returned fetch data for push into the buffer FIFO, and raises dma_stall while DMA owns the port.
- Handles branch redirect, pending redirects during DMA, and bounded DMA bursts for fairness.

---
 rtl/imem_fetch_arbiter.sv | 155 +++++++++++++++
 tb/tb_imem_fetch_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_fetch_arbiter.sv
// Instruction-fetch sequencer sharing the single-ported imem with a DMA master.
// Handles branch redirects (including redirects raised while DMA owns the port) and bounded DMA bursts.
module imem_fetch_arbiter #(
    parameter int              XLEN          = 32,
    parameter logic [XLEN-1:0] RESET_PC      = XLEN'(32'h1000_0000),
    parameter int              DMA_MAX_BURST = 16
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] branch_target_i,
    input  logic            ex_stall_i,
    input  logic            fifo_space_i,
    input  logic [XLEN-1:0] pc_curr_i,
    output logic            pc_write_o,
    output logic [XLEN-1:0] pc_next_o,
    input  logic            dma_req_i,
    input  logic [XLEN-1:0] dma_addr_i,
    input  logic            dma_we_i,
    input  logic [31:0]     dma_wdata_i,
    input  logic            dma_last_i,
    output logic            dma_gnt_o,
    output logic            dma_stall_o,
    output logic            imem_req_o,
    output logic [XLEN-1:0] imem_addr_o,
    output logic            imem_we_o,
    output logic [31:0]     imem_wdata_o,
    output logic            fetch_valid_o,
    output logic [1:0]      state_o
);

    localparam int CNT_W = (DMA_MAX_BURST > 2) ? $clog2(DMA_MAX_BURST) : 1;

    typedef enum logic [1:0] {
        RESET_S = 2'd0,
        FETCH   = 2'd1,
        DMA     = 2'd2,
        FLUSH   = 2'd3
    } state_t;

    state_t          state_reg,          state_next;
    logic [CNT_W-1:0] burst_cnt_reg,     burst_cnt_next;
    logic            pending_branch_reg, pending_branch_next;
    logic [XLEN-1:0] pending_target_reg, pending_target_next;
    logic            dma_block_reg,      dma_block_next;
    logic            fetch_issued_reg;
    logic            fetch_issue;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_reg          <= RESET_S;
            burst_cnt_reg      <= '0;
            pending_branch_reg <= 1'b0;
            pending_target_reg <= '0;
            dma_block_reg      <= 1'b0;
            fetch_issued_reg   <= 1'b0;
        end else begin
            state_reg          <= state_next;
            burst_cnt_reg      <= burst_cnt_next;
            pending_branch_reg <= pending_branch_next;
            pending_target_reg <= pending_target_next;
            dma_block_reg      <= dma_block_next;
            fetch_issued_reg   <= fetch_issue;
        end
    end

    // When no redirect or fetch happens, pc_next_o simply mirrors the current PC.
    always_comb begin
        state_next          = state_reg;
        burst_cnt_next      = burst_cnt_reg;
        pending_branch_next = pending_branch_reg;
        pending_target_next = pending_target_reg;
        dma_block_next      = dma_block_reg;
        fetch_issue         = 1'b0;
        pc_write_o          = 1'b0;
        pc_next_o           = pc_curr_i;
        imem_req_o          = 1'b0;
        imem_addr_o         = '0;
        imem_we_o           = 1'b0;
        imem_wdata_o        = '0;

        case (state_reg)
            RESET_S: begin
                pc_next_o  = RESET_PC;
                state_next = FETCH;
            end

            FETCH: begin
                if (branch_i) begin
                    pc_write_o          = 1'b1;
                    pc_next_o           = branch_target_i;
                    pending_branch_next = 1'b0;
                    dma_block_next      = 1'b0;
                    state_next          = FLUSH;
                end else if (pending_branch_reg) begin
                    pc_write_o          = 1'b1;
                    pc_next_o           = pending_target_reg;
                    pending_branch_next = 1'b0;
                    dma_block_next      = 1'b0;
                    state_next          = FLUSH;
                end else if (dma_req_i && !dma_block_reg) begin
                    burst_cnt_next = '0;
                    state_next     = DMA;
                end else if (fifo_space_i && !ex_stall_i) begin
                    fetch_issue    = 1'b1;
                    imem_req_o     = 1'b1;
                    imem_addr_o    = pc_curr_i;
                    pc_write_o     = 1'b1;
                    pc_next_o      = pc_curr_i + XLEN'(4);
                    dma_block_next = 1'b0;
                end
            end

            DMA: begin
                imem_req_o     = dma_req_i;
                imem_addr_o    = dma_addr_i;
                imem_we_o      = dma_req_i & dma_we_i;
                imem_wdata_o   = dma_wdata_i;
                burst_cnt_next = burst_cnt_reg + CNT_W'(1);
                // A redirect cannot touch the PC while the pipeline is stalled; replay it on exit.
                if (branch_i) begin
                    pending_branch_next = 1'b1;
                    pending_target_next = branch_target_i;
                end
                if (!dma_req_i || dma_last_i) begin
                    burst_cnt_next = '0;
                    state_next     = FETCH;
                end else if (burst_cnt_reg == CNT_W'(DMA_MAX_BURST - 1)) begin
                    burst_cnt_next = '0;
                    dma_block_next = 1'b1;
                    state_next     = FETCH;
                end
            end

            FLUSH: begin
                if (branch_i) begin
                    pc_write_o     = 1'b1;
                    pc_next_o      = branch_target_i;
                    dma_block_next = 1'b0;
                end else begin
                    state_next = FETCH;
                end
            end

            default: state_next = RESET_S;
        endcase
    end

    // The response for the previous cycle's fetch is dropped on a redirect or while flushing.
    assign fetch_valid_o = fetch_issued_reg & ~branch_i & (state_reg != FLUSH);
    assign dma_gnt_o     = (state_reg == DMA);
    assign dma_stall_o   = (state_reg == DMA);
    assign state_o       = state_reg;

endmodule

// File: tb/tb_imem_fetch_arbiter.sv
// Bench for imem_fetch_arbiter: directed sequences, a vector table and random traffic,
// all checked every cycle against a transaction-level model of the arbiter's rules.
module tb_imem_fetch_arbiter;

    localparam int          XLEN     = 32;
    localparam logic [31:0] RESET_PC = 32'h1000_0000;
    localparam int          MAXB     = 16;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        branch_i = 1'b0;
    logic [31:0] branch_target_i = '0;
    logic        ex_stall_i = 1'b0;
    logic        fifo_space_i = 1'b0;
    logic [31:0] pc_curr_i = '0;
    logic        pc_write_o;
    logic [31:0] pc_next_o;
    logic        dma_req_i = 1'b0;
    logic [31:0] dma_addr_i = '0;
    logic        dma_we_i = 1'b0;
    logic [31:0] dma_wdata_i = '0;
    logic        dma_last_i = 1'b0;
    logic        dma_gnt_o, dma_stall_o, imem_req_o, imem_we_o, fetch_valid_o;
    logic [31:0] imem_addr_o, imem_wdata_o;
    logic [1:0]  state_o;

    always #5 clk = ~clk;

    imem_fetch_arbiter #(.XLEN(XLEN), .RESET_PC(RESET_PC), .DMA_MAX_BURST(MAXB)) dut (
        .clk_i(clk), .rst_i(rst_i), .branch_i(branch_i), .branch_target_i(branch_target_i),
        .ex_stall_i(ex_stall_i), .fifo_space_i(fifo_space_i), .pc_curr_i(pc_curr_i),
        .pc_write_o(pc_write_o), .pc_next_o(pc_next_o), .dma_req_i(dma_req_i),
        .dma_addr_i(dma_addr_i), .dma_we_i(dma_we_i), .dma_wdata_i(dma_wdata_i),
        .dma_last_i(dma_last_i), .dma_gnt_o(dma_gnt_o), .dma_stall_o(dma_stall_o),
        .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_we_o(imem_we_o),
        .imem_wdata_o(imem_wdata_o), .fetch_valid_o(fetch_valid_o), .state_o(state_o)
    );

    typedef struct {
        logic        pc_write;
        logic [31:0] pc_next;
        logic        gnt;
        logic        stall;
        logic        req;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic        fv;
        logic [1:0]  state;
    } exp_t;

    typedef struct {
        logic [31:0] pc;
        logic        space;
        logic        stall;
        logic        exp_req;
        logic        exp_pcw;
        logic [31:0] exp_pcn;
    } vec_t;

    // Model state: who owns the port, how many beats DMA has had, and any redirect waiting.
    int          m_mode = 0;        // 0 reset, 1 fetch, 2 dma, 3 flush
    bit          m_pend = 0;
    logic [31:0] m_tgt = '0;
    bit          m_block = 0;
    int          m_beats = 0;
    bit          m_prev_fetch = 0;
    logic [31:0] pc_reg = RESET_PC;

    exp_t        e;
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    bit          use_pc_ovr = 0;
    logic [31:0] pc_ovr = '0;
    logic        o_gnt, o_req, o_pcw, o_fv;
    logic [31:0] o_addr, o_pcn;
    logic [1:0]  o_state;

    int          beats, gcnt, cur_run, fetch_between;
    int          runs[$];
    bit          br_done, saw_redirect, saw_fetch;
    bit          dreq_hold;
    vec_t        vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %h want %h", name, cyc, act, exp);
        end
    endtask

    function automatic exp_t model_out();
        exp_t r;
        r = '{default: '0};
        r.pc_next = pc_curr_i;
        case (m_mode)
            0: r.pc_next = RESET_PC;
            1: begin
                if (branch_i) begin
                    r.pc_write = 1'b1; r.pc_next = branch_target_i;
                end else if (m_pend) begin
                    r.pc_write = 1'b1; r.pc_next = m_tgt;
                end else if (dma_req_i && !m_block) begin
                    r.pc_write = 1'b0;
                end else if (fifo_space_i && !ex_stall_i) begin
                    r.req = 1'b1; r.addr = pc_curr_i;
                    r.pc_write = 1'b1; r.pc_next = pc_curr_i + 32'd4;
                end
            end
            2: begin
                r.gnt = 1'b1; r.stall = 1'b1; r.req = dma_req_i;
                r.addr = dma_addr_i; r.we = dma_req_i & dma_we_i; r.wdata = dma_wdata_i;
            end
            default: begin
                if (branch_i) begin
                    r.pc_write = 1'b1; r.pc_next = branch_target_i;
                end
            end
        endcase
        r.fv = m_prev_fetch && !branch_i && (m_mode != 3);
        r.state = 2'(m_mode);
        return r;
    endfunction

    function automatic void model_step();
        if (rst_i) begin
            m_mode = 0; m_pend = 0; m_tgt = '0; m_block = 0; m_beats = 0;
            m_prev_fetch = 0; pc_reg = RESET_PC;
            return;
        end
        m_prev_fetch = e.req && (m_mode == 1);
        if (e.pc_write) pc_reg = e.pc_next;
        case (m_mode)
            0: m_mode = 1;
            1: begin
                if (branch_i || m_pend) begin
                    m_pend = 0; m_block = 0; m_mode = 3;
                end else if (dma_req_i && !m_block) begin
                    m_mode = 2; m_beats = 0;
                end else if (fifo_space_i && !ex_stall_i) begin
                    m_block = 0;
                end
            end
            2: begin
                m_beats++;
                if (branch_i) begin
                    m_pend = 1; m_tgt = branch_target_i;
                end
                if (!dma_req_i || dma_last_i) begin
                    m_mode = 1; m_beats = 0;
                end else if (m_beats == MAXB) begin
                    m_mode = 1; m_block = 1; m_beats = 0;
                end
            end
            default: begin
                if (branch_i) m_block = 0;
                else m_mode = 1;
            end
        endcase
    endfunction

    // One clock: drive PC, compare every output at the falling edge, advance the model.
    task automatic tick();
        pc_curr_i = use_pc_ovr ? pc_ovr : pc_reg;
        @(negedge clk);
        e = model_out();
        o_gnt = dma_gnt_o; o_req = imem_req_o; o_pcw = pc_write_o; o_fv = fetch_valid_o;
        o_addr = imem_addr_o; o_pcn = pc_next_o; o_state = state_o;
        chk("pc_write", pc_write_o, e.pc_write);
        chk("pc_next", pc_next_o, e.pc_next);
        chk("dma_gnt", dma_gnt_o, e.gnt);
        chk("dma_stall", dma_stall_o, e.stall);
        chk("imem_req", imem_req_o, e.req);
        chk("imem_addr", imem_addr_o, e.addr);
        chk("imem_we", imem_we_o, e.we);
        chk("imem_wdata", imem_wdata_o, e.wdata);
        chk("fetch_valid", fetch_valid_o, e.fv);
        chk("state", state_o, e.state);
        @(posedge clk);
        model_step();
        cyc++;
        #1;
    endtask

    initial begin
        vecs[0] = '{32'hFFFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0000};
        vecs[1] = '{32'h0000_1230, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_1234};
        vecs[2] = '{32'h8000_0000, 1'b0, 1'b0, 1'b0, 1'b0, 32'h8000_0000};
        vecs[3] = '{32'h8000_0000, 1'b1, 1'b1, 1'b0, 1'b0, 32'h8000_0000};
        vecs[4] = '{32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0, 32'h8000_0000};
        vecs[5] = '{32'h7FFF_FFFC, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8000_0000};

        // Reset, then check the reset-state outputs while reset is still held.
        rst_i = 1'b1;
        @(posedge clk);
        model_step();
        #1;
        tick();
        tick();

        // Boot: RESET_S idle, then three sequential fetches, valid one cycle later.
        rst_i = 1'b0;
        fifo_space_i = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (i == 0) chk("boot_idle", o_req, 1'b0);
            else if (i < 4) chk("boot_addr", o_addr, RESET_PC + 32'(4 * (i - 1)));
            if (i >= 2) chk("boot_fv", o_fv, 1'b1);
        end

        // Branch during streaming: redirect, flush, fetch at target.
        branch_i = 1'b1; branch_target_i = 32'h1000_0100;
        tick();
        chk("br_pc_next", o_pcn, 32'h1000_0100);
        chk("br_fv_masked", o_fv, 1'b0);
        branch_i = 1'b0;
        tick();
        chk("br_flush_state", o_state, 2'd3);
        chk("br_flush_fv", o_fv, 1'b0);
        tick();
        chk("br_fetch_addr", o_addr, 32'h1000_0100);

        // Four-beat DMA transfer ending on dma_last_i.
        beats = 0; gcnt = 0;
        for (int i = 0; i < 10; i++) begin
            dma_req_i = (beats < 4); dma_last_i = (beats == 3); dma_we_i = beats[0];
            dma_addr_i = 32'h0000_0100 + 32'(beats * 4); dma_wdata_i = $urandom;
            tick();
            if (o_gnt) gcnt++;
            if (e.gnt && dma_req_i) beats++;
        end
        chk("dma4_gnt_cycles", gcnt, 4);

        // Twenty beats held: forced release after the burst limit, one fetch, then regrant.
        beats = 0; cur_run = 0; fetch_between = 0; runs.delete();
        for (int i = 0; i < 40; i++) begin
            dma_req_i = (beats < 20); dma_last_i = (beats == 19); dma_we_i = 1'b1;
            dma_addr_i = 32'h0000_0200 + 32'(beats * 4); dma_wdata_i = $urandom;
            tick();
            if (o_gnt) cur_run++;
            else if (cur_run > 0) begin runs.push_back(cur_run); cur_run = 0; end
            if (o_req && !o_gnt && runs.size() == 1 && cur_run == 0) fetch_between++;
            if (e.gnt && dma_req_i) beats++;
        end
        chk("burst_runs", runs.size(), 2);
        if (runs.size() >= 2) begin
            chk("burst_first_len", runs[0], MAXB);
            chk("burst_second_len", runs[1], 4);
        end
        chk("burst_fetch_between", fetch_between, 1);

        // Branch mid-DMA is held and replayed when the port returns to fetch.
        beats = 0; br_done = 0; saw_redirect = 0; saw_fetch = 0; dma_we_i = 1'b0;
        for (int i = 0; i < 16; i++) begin
            dma_req_i = (beats < 5); dma_last_i = (beats == 4);
            branch_i = (m_mode == 2 && beats == 2 && !br_done);
            if (branch_i) br_done = 1;
            branch_target_i = 32'h2000_0000;
            tick();
            if (o_pcw && o_pcn == 32'h2000_0000 && o_state == 2'd1) saw_redirect = 1;
            if (o_req && o_addr == 32'h2000_0000 && o_state == 2'd1) saw_fetch = 1;
            if (e.gnt && dma_req_i) beats++;
        end
        branch_i = 1'b0;
        chk("dma_br_redirect", saw_redirect, 1'b1);
        chk("dma_br_fetch", saw_fetch, 1'b1);

        // Vector table: PC wrap and the fetch-blocking conditions.
        dma_req_i = 1'b0; dma_last_i = 1'b0;
        use_pc_ovr = 1;
        foreach (vecs[k]) begin
            pc_ovr = vecs[k].pc; fifo_space_i = vecs[k].space; ex_stall_i = vecs[k].stall;
            tick();
            chk("vec_req", o_req, vecs[k].exp_req);
            chk("vec_pc_write", o_pcw, vecs[k].exp_pcw);
            if (vecs[k].exp_pcw) chk("vec_pc_next", o_pcn, vecs[k].exp_pcn);
        end
        use_pc_ovr = 0; ex_stall_i = 1'b0;

        // Random traffic, including occasional reset mid-transfer.
        dreq_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            rst_i = ($urandom_range(0, 199) == 0);
            branch_i = ($urandom_range(0, 15) == 0);
            branch_target_i = $urandom & 32'hFFFF_FFFC;
            ex_stall_i = ($urandom_range(0, 4) == 0);
            fifo_space_i = ($urandom_range(0, 3) != 0);
            if (!dreq_hold) dreq_hold = ($urandom_range(0, 9) == 0);
            else dreq_hold = ($urandom_range(0, 11) != 0);
            dma_req_i = dreq_hold;
            dma_last_i = (i < 1500) ? ($urandom_range(0, 5) == 0) : ($urandom_range(0, 29) == 0);
            dma_we_i = $urandom_range(0, 1);
            dma_addr_i = $urandom;
            dma_wdata_i = $urandom;
            use_pc_ovr = ($urandom_range(0, 7) == 0);
            pc_ovr = $urandom & 32'hFFFF_FFFC;
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
